cmos_16_8bit_tx: RTL

Serialises a stream of 16-bit RGB565 pixels into an 8-bit DVP-style camera bus (pdata/de/vs) on a single byte clock. It is the transmit-side counterpart of the camera 8→16 packer. Uses:
- camera emulator / loopback source for bring-up of the capture path;
- driving an external 8-bit parallel sink.

An internal FIFO absorbs the upstream pixel rate. A frame FSM generates the VS, back-porch, active-line, H-blank and front-porch timing.

---
 rtl/cmos_16_8bit_tx_pkg.sv | 37 +++
 rtl/cmos_16_8bit_tx_if.sv | 26 ++
 rtl/cmos_16_8bit_tx_fifo.sv | 74 +++++++
 rtl/cmos_16_8bit_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cmos_16_8bit_tx_pkg.sv
// Shared types and helpers for the 16-to-8 bit DVP transmitter.
// Holds the frame FSM state enum, the FIFO entry layout and width helpers
// used to size the pixel, line and timing counters from the top parameters.
package cmos_tx_pkg;

    localparam int unsigned PIX_W   = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ENTRY_W = 17;

    // FIFO entry: start-of-frame marker above the RGB565 pixel
    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] data;
    } pix_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        PRE,
        ACT_HI,
        ACT_LO,
        HBLANK,
        VFP
    } tx_state_t;

    // Bits needed to hold values 0..max_val (at least 1)
    function automatic int unsigned cnt_w(input int unsigned max_val);
        if (max_val == 0) return 1;
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cmos_16_8bit_tx_if.sv
// Pixel stream and DVP byte bus of the transmitter.
//   pix_valid/pix_ready/pix_data/pix_sof : upstream RGB565 pixel handshake
//   vs_o/de_o/pdata_o                    : 8-bit camera-style output bus
// master = pixel source / DVP sink side, slave = transmitter side.
interface cmos_16_8bit_tx_if;
    import cmos_tx_pkg::*;

    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_sof;
    logic              vs_o;
    logic              de_o;
    logic [BYTE_W-1:0] pdata_o;

    modport master (
        output pix_valid, pix_data, pix_sof,
        input  pix_ready, vs_o, de_o, pdata_o
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof,
        output pix_ready, vs_o, de_o, pdata_o
    );

endinterface

// File: rtl/cmos_16_8bit_tx_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst    : clock, asynchronous active-high reset
//   i_push      : write i_data (ignored when full)
//   i_pop       : drop the head entry (ignored when empty)
//   o_head      : current head entry, valid while !o_empty
//   o_full, o_empty, o_count : occupancy status
//   o_ready     : registered !full, computed from next-cycle occupancy
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 17,
    parameter int unsigned CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ready,
    output logic [CW-1:0]    o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_ready;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && (r_count != CW'(DEPTH));
    assign w_pop  = i_pop  && (r_count != '0);

    // Occupancy after this edge; drives the registered ready
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
        end else begin
            if (w_push) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
            if (w_pop)  r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != CW'(DEPTH));
        end
    end

    // Storage has no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_ready = r_ready;
    assign o_count = r_count;

endmodule

// File: rtl/cmos_16_8bit_tx.sv
// RGB565 pixel stream to 8-bit DVP serialiser with frame timing generation.
//   pclk, rst : byte clock, asynchronous active-high reset
//   bus       : pixel handshake in, vs_o/de_o/pdata_o out (registered)
//   clr_err   : synchronous clear of the sticky flags (wins over a set)
//   busy      : frame FSM not in IDLE
//   underflow : sticky, FIFO empty at a pixel slot of an active line
//   sync_err  : sticky, sof pixel popped after the first pixel of a frame
module cmos_16_8bit_tx
    import cmos_tx_pkg::*;
#(
    parameter int unsigned H_PIXELS      = 640,
    parameter int unsigned V_LINES       = 480,
    parameter int unsigned VS_CYCLES     = 16,
    parameter int unsigned VBP_CYCLES    = 32,
    parameter int unsigned HBLANK_CYCLES = 64,
    parameter int unsigned VFP_CYCLES    = 32,
    parameter int unsigned FIFO_DEPTH    = 1024,
    parameter int unsigned PRELOAD       = 256
) (
    input  logic                 pclk,
    input  logic                 rst,
    cmos_16_8bit_tx_if.slave     bus,
    input  logic                 clr_err,
    output logic                 busy,
    output logic                 underflow,
    output logic                 sync_err
);

    localparam int unsigned PW   = cnt_w(H_PIXELS);
    localparam int unsigned LW   = cnt_w(V_LINES);
    localparam int unsigned TMAX = max2(max2(VS_CYCLES, VBP_CYCLES),
                                        max2(HBLANK_CYCLES, VFP_CYCLES));
    localparam int unsigned TW   = cnt_w(TMAX);
    localparam int unsigned CW   = cnt_w(FIFO_DEPTH);

    tx_state_t          r_state;
    tx_state_t          w_next;
    logic [PW-1:0]      r_pix;
    logic [LW-1:0]      r_line;
    logic [TW-1:0]      r_tmr;
    logic               r_skip;
    logic               r_vs;
    logic               r_de;
    logic [BYTE_W-1:0]  r_pdata;
    logic               r_busy;
    logic               r_uf;
    logic               r_se;

    pix_entry_t         w_wr_entry;
    pix_entry_t         w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_ready;
    logic [CW-1:0]      w_count;
    logic               w_push;

    logic               w_vs;
    logic               w_de;
    logic [BYTE_W-1:0]  w_pdata;
    logic               w_pop;
    logic               w_set_uf;
    logic               w_set_se;
    logic               w_tmr_run;
    logic               w_line_end;

    assign w_wr_entry = '{sof: bus.pix_sof, data: bus.pix_data};
    assign w_push     = bus.pix_valid && !w_full;
    assign w_line_end = (r_pix == PW'(H_PIXELS - 1));

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CW    (CW)
    ) u_fifo (
        .clk     (pclk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_ready (w_ready),
        .o_count (w_count)
    );

    // State register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (!w_empty && w_head.sof)              w_next = VSYNC;
            VSYNC:  if (r_tmr == TW'(VS_CYCLES - 1))         w_next = VBP;
            VBP:    if (r_tmr == TW'(VBP_CYCLES - 1))        w_next = PRE;
            PRE:    if (w_count >= CW'(PRELOAD))             w_next = ACT_HI;
            ACT_HI:                                          w_next = ACT_LO;
            ACT_LO:                                          w_next = w_line_end ? HBLANK : ACT_HI;
            HBLANK: if (r_tmr == TW'(HBLANK_CYCLES - 1))
                        w_next = (r_line == LW'(V_LINES)) ? VFP : PRE;
            VFP:    if (r_tmr == TW'(VFP_CYCLES - 1))        w_next = IDLE;
            default:                                         w_next = IDLE;
        endcase
    end

    // Output / control decode from the current state
    always_comb begin
        w_vs      = 1'b0;
        w_de      = 1'b0;
        w_pdata   = '0;
        w_pop     = 1'b0;
        w_set_uf  = 1'b0;
        w_set_se  = 1'b0;
        w_tmr_run = 1'b0;
        case (r_state)
            IDLE: w_pop = !w_empty && !w_head.sof;
            VSYNC: begin
                w_vs      = 1'b1;
                w_tmr_run = 1'b1;
            end
            VBP, HBLANK, VFP: w_tmr_run = 1'b1;
            ACT_HI: begin
                w_de = 1'b1;
                if (w_empty) w_set_uf = 1'b1;
                else         w_pdata  = w_head.data[PIX_W-1:BYTE_W];
            end
            ACT_LO: begin
                w_de = 1'b1;
                // A starved HI slot leaves its pixel unpopped and sends 0x00 here too
                if (!r_skip) begin
                    w_pdata  = w_head.data[BYTE_W-1:0];
                    w_pop    = 1'b1;
                    w_set_se = w_head.sof && !((r_pix == '0) && (r_line == '0));
                end
            end
            default: ;
        endcase
    end

    // Counters, registered outputs and sticky flags
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_tmr   <= '0;
            r_pix   <= '0;
            r_line  <= '0;
            r_skip  <= 1'b0;
            r_vs    <= 1'b0;
            r_de    <= 1'b0;
            r_pdata <= '0;
            r_busy  <= 1'b0;
            r_uf    <= 1'b0;
            r_se    <= 1'b0;
        end else begin
            r_tmr <= (w_tmr_run && (w_next == r_state)) ? r_tmr + TW'(1) : '0;
            if (r_state == ACT_HI) r_skip <= w_empty;
            if (r_state == ACT_LO) r_pix <= w_line_end ? '0 : r_pix + PW'(1);
            if (r_state == IDLE) begin
                r_line <= '0;
            end else if ((r_state == ACT_LO) && w_line_end) begin
                r_line <= r_line + LW'(1);
            end
            r_vs    <= w_vs;
            r_de    <= w_de;
            r_pdata <= w_pdata;
            r_busy  <= (w_next != IDLE);
            r_uf    <= clr_err ? 1'b0 : (r_uf | w_set_uf);
            r_se    <= clr_err ? 1'b0 : (r_se | w_set_se);
        end
    end

    assign bus.pix_ready = w_ready;
    assign bus.vs_o      = r_vs;
    assign bus.de_o      = r_de;
    assign bus.pdata_o   = r_pdata;
    assign busy          = r_busy;
    assign underflow     = r_uf;
    assign sync_err      = r_se;

endmodule
